// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, captures imem words into an in-order queue for decode.
// Optional performance counters are built in when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter int unsigned           PC_WIDTH    = 32,
    parameter int unsigned           INST_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter int unsigned           QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [INST_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic                  misaligned
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]   fpc_q,   fpc_d;
    logic [PTR_W-1:0]      head_q,  head_d;
    logic [PTR_W-1:0]      tail_q,  tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PC_WIDTH-1:0]   pc_mem_q   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [QUEUE_DEPTH];

    logic pop_c;
    logic push_c;
    logic full_c;

    // Outputs are decodes of state registers only, so they cannot glitch on input changes.
    assign imem_pc    = fpc_q;
    assign misaligned = |fpc_q[1:0];
    assign out_valid  = (count_q != '0);
    assign out_pc     = pc_mem_q[head_q];
    assign out_inst   = inst_mem_q[head_q];

    // Next-state: redirect beats everything; a full queue accepts a push only alongside a pop.
    always_comb begin
        full_c  = (count_q == CNT_W'(QUEUE_DEPTH));
        pop_c   = out_valid & out_ready;
        push_c  = !redirect_valid && !misaligned && (!full_c || pop_c);
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            fpc_d   = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                fpc_d  = fpc_q + PC_WIDTH'(4);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; written at the tail on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (push_c) begin
            pc_mem_q[tail_q]   <= fpc_q;
            inst_mem_q[tail_q] <= imem_inst;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;
    logic        stall_c;

    // A stall is a cycle lost only to a full queue with no draining pop.
    assign stall_c = !redirect_valid && !misaligned && full_c && !pop_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push_c) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (stall_c) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
